// File: rtl/l2_evict_buffer_if.sv
// L2-controller side of the eviction write buffer: request, victim data and completion.
interface l2_evict_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              physical_read;
    logic              physical_write;
    logic              load_ewb;
    logic [ADDR_W-1:0] physical_address;
    logic [LINE_W-1:0] physical_wdata;
    logic [LINE_W-1:0] physical_rdata;
    logic              physical_resp;
    logic              isEmpty;
    logic              isReady;

    modport master (
        output physical_read, physical_write, load_ewb, physical_address, physical_wdata,
        input  physical_rdata, physical_resp, isEmpty, isReady
    );

    modport slave (
        input  physical_read, physical_write, load_ewb, physical_address, physical_wdata,
        output physical_rdata, physical_resp, isEmpty, isReady
    );
endinterface

// File: rtl/l2_evict_buffer.sv
// Eviction write buffer: holds dirty L2 victims, drains them to memory when idle,
// and forwards reads from buffered lines on a line-address match.
//
// state    | meaning
// IDLE     | sample requests: read > write (not full) > drain (not empty)
// CAPT     | victim stored at tail, completion pulse
// HIT      | read served from youngest matching entry, completion pulse
// FWD      | read miss, memory read held until mem_resp
// FWD_RESP | memory data returned, completion pulse
// DRAIN    | head entry written to memory, held until mem_resp
module l2_evict_buffer #(
    parameter int DEPTH    = 2,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    l2_evict_buffer_if.slave  l2,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPT, S_HIT, S_FWD, S_FWD_RESP, S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q  [DEPTH];
    logic [LINE_W-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [LINE_W-1:0]  rdata_q;

    logic [TAG_W-1:0]   req_tag;
    logic [PTR_W-1:0]   idx;
    logic               hit;
    logic [LINE_W-1:0]  hit_data;
    logic               full;
    logic               do_read;
    logic               do_capt;

    assign req_tag = l2.physical_address[ADDR_W-1:OFFSET_W];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_read = (state_q == S_IDLE) && l2.physical_read;
    assign do_capt = (state_q == S_IDLE) && !l2.physical_read && l2.physical_write
                     && l2.load_ewb && !full;

    // Walk oldest to youngest so the last match seen is the youngest copy.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] && (tag_q[idx] == req_tag)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (l2.physical_read) begin
                    state_d = hit ? S_HIT : S_FWD;
                end else if (do_capt) begin
                    state_d = S_CAPT;
                end else if (count_q != '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_CAPT, S_HIT, S_FWD_RESP: state_d = S_IDLE;
            S_FWD:   if (mem_resp) state_d = S_FWD_RESP;
            S_DRAIN: if (mem_resp) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            req_tag_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (do_read) begin
                req_tag_q <= req_tag;
                if (hit) rdata_q <= hit_data;
            end
            if (do_capt) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
                count_q         <= count_q + CNT_W'(1);
            end
            if ((state_q == S_FWD) && mem_resp) begin
                rdata_q <= mem_rdata;
            end
            if ((state_q == S_DRAIN) && mem_resp) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
                count_q         <= count_q - CNT_W'(1);
            end
        end
    end

    // Line storage needs no reset: valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (do_capt) begin
            tag_q[tail_q]  <= req_tag;
            data_q[tail_q] <= l2.physical_wdata;
        end
    end

    always_comb begin
        l2.physical_resp  = 1'b0;
        l2.physical_rdata = rdata_q;
        l2.isEmpty        = (count_q == '0);
        l2.isReady        = (state_q == S_IDLE);
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_address       = '0;
        mem_wdata         = '0;
        case (state_q)
            S_CAPT, S_HIT, S_FWD_RESP: l2.physical_resp = 1'b1;
            S_FWD: begin
                mem_read    = 1'b1;
                mem_address = {req_tag_q, {OFFSET_W{1'b0}}};
            end
            S_DRAIN: begin
                mem_write   = 1'b1;
                mem_address = {tag_q[head_q], {OFFSET_W{1'b0}}};
                mem_wdata   = data_q[head_q];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_l2_evict_buffer.sv
// Self-checking bench for l2_evict_buffer: directed scenarios plus random traffic
// checked against a queue-of-lines model with a backing memory array.
module tb_l2_evict_buffer;
    localparam int DEPTH    = 2;
    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l2_evict_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) l2 ();

    logic              mem_read, mem_write, mem_resp;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;

    l2_evict_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)) dut (
        .clk(clk), .rst_n(rst_n), .l2(l2),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    typedef struct { logic [31:0] addr; logic [255:0] data; } ent_t;
    ent_t         q[$];
    logic [31:0]  drain_log[$];
    logic [255:0] drain_dlog[$];
    logic [255:0] mem_arr [logic [31:0]];

    int tests_run = 0, tests_failed = 0;
    int cur_op = 0;            // 0 none, 1 read, 2 write, 3 unqualified write
    int op_id = 0;
    logic [31:0]  cur_addr = '0;
    logic [255:0] cur_data = '0;
    int  mem_lat = 1;
    bit  stall = 1'b0;
    int  rd_cycles = 0;

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    function automatic logic [255:0] mem_val(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory: responds mem_lat cycles after a strobe appears; stall holds it off.
    initial begin
        int cnt;
        cnt = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || mem_resp) begin
                mem_resp = 1'b0;
                cnt = 0;
            end else if ((mem_read || mem_write) && !stall) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_resp = 1'b1;
                    cnt = 0;
                    if (mem_read) mem_rdata = mem_val(mem_address);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        int seen_op, op_reads;
        bit hit;
        logic [255:0] exp_d;
        seen_op = -1;
        op_reads = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                continue;
            end
            if (op_id != seen_op) begin
                seen_op = op_id;
                op_reads = 0;
            end
            chk("strobe_exclusive", {255'b0, mem_read && mem_write}, 256'd0);
            if (mem_read) begin
                rd_cycles++;
                op_reads++;
                chk("mem_read_addr", mem_address, align(cur_addr));
            end
            if (l2.physical_resp) begin
                if (cur_op == 2) begin
                    q.push_back('{align(cur_addr), cur_data});
                end else if (cur_op == 1) begin
                    hit = 1'b0;
                    exp_d = mem_val(align(cur_addr));
                    foreach (q[i]) if (q[i].addr == align(cur_addr)) begin
                        hit = 1'b1;
                        exp_d = q[i].data;
                    end
                    chk("read_data", l2.physical_rdata, exp_d);
                    if (hit) chk("hit_no_mem_read", op_reads, 0);
                end else begin
                    chk("unexpected_resp", 1, 0);
                end
            end
            chk("isEmpty", l2.isEmpty, q.size() == 0);
            if (mem_write) begin
                if (q.size() == 0) begin
                    chk("drain_when_empty", 1, 0);
                end else begin
                    chk("drain_addr", mem_address, q[0].addr);
                    chk("drain_data", mem_wdata, q[0].data);
                    if (mem_resp) begin
                        mem_arr[q[0].addr] = q[0].data;
                        drain_log.push_back(q[0].addr);
                        drain_dlog.push_back(q[0].data);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // lat counts cycles since the last IDLE sampling edge; tot counts all cycles waited.
    task automatic wait_resp(output int lat, output int tot);
        bit was_rdy;
        lat = 0;
        tot = 0;
        forever begin
            was_rdy = l2.isReady;
            @(posedge clk); #1;
            tot++;
            if (was_rdy) lat = 0;
            lat++;
            if (l2.physical_resp) break;
            if (tot > 300) begin
                chk("resp_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic drop_req();
        l2.physical_read  = 1'b0;
        l2.physical_write = 1'b0;
        l2.load_ewb       = 1'b0;
    endtask

    task automatic run_op(input int op, input logic [31:0] addr, input logic [255:0] data,
                          output int lat, output int tot);
        op_id++;
        cur_op = op;
        cur_addr = addr;
        cur_data = data;
        l2.physical_address = addr;
        l2.physical_wdata   = data;
        l2.physical_read    = (op == 1);
        l2.physical_write   = (op == 2);
        l2.load_ewb         = (op == 2);
        wait_resp(lat, tot);
        drop_req();
        @(negedge clk); #1;
        cur_op = 0;
    endtask

    task automatic run_both(input logic [31:0] addr, input logic [255:0] data);
        int lat, tot;
        op_id++;
        cur_op = 1;
        cur_addr = addr;
        cur_data = data;
        l2.physical_address = addr;
        l2.physical_wdata   = data;
        l2.physical_read    = 1'b1;
        l2.physical_write   = 1'b1;
        l2.load_ewb         = 1'b1;
        wait_resp(lat, tot);
        l2.physical_read = 1'b0;
        @(negedge clk); #1;
        op_id++;
        cur_op = 2;
        wait_resp(lat, tot);
        drop_req();
        @(negedge clk); #1;
        cur_op = 0;
    endtask

    task automatic run_unqualified(input logic [31:0] addr, input logic [255:0] data);
        op_id++;
        cur_op = 3;
        cur_addr = addr;
        l2.physical_address = addr;
        l2.physical_wdata   = data;
        l2.physical_write   = 1'b1;
        l2.load_ewb         = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drop_req();
        @(negedge clk); #1;
        cur_op = 0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!(l2.isEmpty && l2.isReady && !mem_resp)) begin
            @(posedge clk); #1;
            n++;
            if (n > 400) begin
                chk("empty_timeout", 1, 0);
                break;
            end
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < drain_log.size()) return drain_log[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [255:0] dlog_at(input int i);
        if (i < drain_dlog.size()) return drain_dlog[i];
        return '1;
    endfunction

    localparam logic [255:0] LA = {8{32'hAAAA_0001}};
    localparam logic [255:0] LB = {8{32'hBBBB_0002}};
    localparam logic [255:0] LC = {8{32'hCCCC_0003}};
    localparam logic [255:0] LD = {8{32'hDDDD_0004}};
    localparam logic [255:0] LE = {8{32'hEEEE_0005}};

    initial begin
        int lat, tot, rd0, n;
        logic [31:0] pool [4];
        pool[0] = 32'h0000_1000; pool[1] = 32'h0000_1020;
        pool[2] = 32'h0000_1040; pool[3] = 32'h0000_2000;

        rst_n = 1'b0;
        drop_req();
        l2.physical_address = '0;
        l2.physical_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp", l2.physical_resp, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_rdata", l2.physical_rdata, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_isEmpty", l2.isEmpty, 1);
        chk("rst_isReady", l2.isReady, 1);
        rst_n = 1'b1;

        // 1: single capture then drain
        mem_lat = 3;
        drain_log.delete(); drain_dlog.delete();
        run_op(2, 32'h0000_1040, LA, lat, tot);
        chk("t1_capture_latency", lat, 1);
        chk("t1_not_empty", l2.isEmpty, 0);
        wait_empty();
        chk("t1_drain_addr", log_at(0), 32'h0000_1040);
        chk("t1_drain_data", dlog_at(0), LA);

        // 2: read hit before drain starts
        run_op(2, 32'h0000_2000, LA, lat, tot);
        rd0 = rd_cycles;
        run_op(1, 32'h0000_2004, '0, lat, tot);
        chk("t2_hit_latency", lat, 1);
        chk("t2_hit_data", l2.physical_rdata, LA);
        chk("t2_no_mem_read", rd_cycles - rd0, 0);
        wait_empty();

        // 3: read miss with 5-cycle memory
        mem_arr[32'h0000_3000] = LB;
        mem_lat = 5;
        rd0 = rd_cycles;
        run_op(1, 32'h0000_3000, '0, lat, tot);
        chk("t3_miss_latency", lat, 6);
        chk("t3_mem_read_cycles", rd_cycles - rd0, 5);
        chk("t3_miss_data", l2.physical_rdata, LB);

        // 4: write while full waits for the head drain
        mem_lat = 1;
        stall = 1'b1;
        drain_log.delete(); drain_dlog.delete();
        run_op(2, 32'h0000_0100, LA, lat, tot);
        run_op(2, 32'h0000_0200, LB, lat, tot);
        fork
            run_op(2, 32'h0000_0300, LC, lat, tot);
            begin repeat (8) @(posedge clk); #1; stall = 1'b0; end
        join
        chk("t4_c_waited", tot >= 8, 1);
        chk("t4_first_drain", log_at(0), 32'h0000_0100);
        chk("t4_one_drain_before_c", drain_log.size(), 1);
        wait_empty();
        chk("t4_drain_count", drain_log.size(), 3);
        chk("t4_second_drain", log_at(1), 32'h0000_0200);
        chk("t4_third_drain", log_at(2), 32'h0000_0300);

        // 5: duplicate victims, forward youngest, drain in order
        mem_lat = 2;
        drain_log.delete(); drain_dlog.delete();
        run_op(2, 32'h0000_0400, LA, lat, tot);
        run_op(2, 32'h0000_0400, LD, lat, tot);
        run_op(1, 32'h0000_0400, '0, lat, tot);
        chk("t5_youngest", l2.physical_rdata, LD);
        wait_empty();
        chk("t5_drain0", dlog_at(0), LA);
        chk("t5_drain1", dlog_at(1), LD);

        // 6: reset mid-drain
        stall = 1'b1;
        run_op(2, 32'h0000_0500, LE, lat, tot);
        n = 0;
        while (!mem_write && n < 20) begin @(posedge clk); #1; n++; end
        chk("t6_drain_started", mem_write, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_mem_write", mem_write, 0);
        chk("t6_isEmpty", l2.isEmpty, 1);
        chk("t6_isReady", l2.isReady, 1);
        rst_n = 1'b1;
        stall = 1'b0;
        drain_log.delete(); drain_dlog.delete();
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_later_drain", drain_log.size(), 0);

        // random traffic
        for (int it = 0; it < 250; it++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            mem_lat = $urandom_range(1, 4);
            if (r <= 3)      run_op(2, a, rnd_line(), lat, tot);
            else if (r <= 6) run_op(1, a, '0, lat, tot);
            else if (r == 7) run_both(a, rnd_line());
            else if (r == 8) run_unqualified(a, rnd_line());
            else begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
            end
        end
        wait_empty();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/l2_evict_buffer.md
Name: l2_evict_buffer

Overview:
Eviction write buffer between the L2 cache controller and physical memory. It terminates the controller's physical_read/physical_write initiator interface and returns physical_resp, isEmpty and isReady. It holds dirty victim lines and drains them to memory when the memory port is idle. Reads bypass pending drains and are forwarded from the buffer on an address match.

Parameters:
DEPTH, 2, number of victim-line entries; must be a power of 2 and at least 2
ADDR_W, 32, physical address width
LINE_W, 256, cache line width in bits
OFFSET_W, 5, line-offset bits; ignored in compares and forced to 0 on the memory address

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
physical_read  in  1  L2 line-read request
physical_write  in  1  L2 victim write request
load_ewb  in  1  qualifies physical_write; a write is captured only when both are high
physical_address  in  ADDR_W  request address
physical_wdata  in  LINE_W  victim line
physical_rdata  out  LINE_W  read line, valid while physical_resp is high
physical_resp  out  1  one-cycle completion pulse
isEmpty  out  1  entry count is 0
isReady  out  1  block can sample a request this cycle (state IDLE)
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  line-aligned memory address
mem_wdata  out  LINE_W  line written to memory
mem_rdata  in  LINE_W  memory read data
mem_resp  in  1  memory completion

Behaviour:
- Decided: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: state IDLE; head, tail and count are 0; all valid bits are 0.
  - physical_resp, mem_read and mem_write are 0; physical_rdata and mem_address are 0.
  - isEmpty=1 and isReady=1.
  - Reset mid-FWD or mid-DRAIN aborts the operation. All entries are discarded and the strobes drop on the next cycle.
- States: IDLE, CAPT, HIT, FWD, FWD_RESP, DRAIN.
- Requests are sampled only in IDLE. Priority in IDLE, highest first:
  - read;
  - write, when count<DEPTH;
  - drain, when count>0.
- Read, hit path:
  - Compare address bits [ADDR_W-1:OFFSET_W] against all valid entries.
  - On a match, go to HIT. physical_rdata is taken from the youngest matching entry and physical_resp=1 for that single cycle.
  - No memory access occurs. Latency is 1 cycle.
- Read, miss path:
  - Go to FWD and assert mem_read with the aligned address. Address and strobe are held stable until mem_resp.
  - On the mem_resp cycle, register mem_rdata and go to FWD_RESP. FWD_RESP pulses physical_resp for one cycle, then returns to IDLE.
- Write capture:
  - Store the aligned address and wdata at tail; tail=(tail+1) mod DEPTH; count+1; go to CAPT.
  - CAPT pulses physical_resp for one cycle. Latency is 1 cycle and independent of memory.
- Write while full: the request is not sampled. The block drains the head entry first, returns to IDLE, then captures. physical_resp is delayed accordingly.
- Drain:
  - In DRAIN, assert mem_write with the head address and data, held until mem_resp.
  - On mem_resp, clear the head valid bit; head=(head+1) mod DEPTH; count-1; return to IDLE.
  - A drain is never preempted. A read arriving during DRAIN waits, with isReady=0.
- The requester holds each request until physical_resp. It must deassert the request in the cycle after physical_resp, or it is re-sampled as a new request.
- If physical_read and physical_write are both high, the read is served and the write stays pending.
- Duplicate victim addresses occupy separate entries. They drain in FIFO order, and forwarding returns the youngest.
- isEmpty is combinational from count. isReady=(state==IDLE).
- mem_read and mem_write are never high together.

Test Plan:
1. Reset, then write 0x0000_1040 with data A, load_ewb=1. Required: physical_resp exactly 1 cycle later with isEmpty=0. After idle, mem_write to 0x0000_1040 with A; after mem_resp, isEmpty=1.
2. Capture 0x2000 (data A), then read 0x2004 before the drain starts. Required: physical_rdata=A one cycle later and no mem_read pulse.
3. Read 0x3000 while the buffer is empty, memory responds after 5 cycles with B. Required: mem_read held 5 cycles at address 0x3000; physical_resp=1 with rdata=B the cycle after mem_resp.
4. DEPTH=2: write 0x100 (A) and 0x200 (B) while memory is stalled, then write 0x300 (C). Required: C waits; 0x100 drains first; then C is captured and resp is pulsed. Final drain order: 0x200, then 0x300.
5. Write 0x400 twice, first with A then with D, then read 0x400. Required: rdata=D, then drains A followed by D.
6. Assert rst_n=0 mid-DRAIN. Required: mem_write=0, isEmpty=1 and isReady=1 on the next cycle, and no later drain occurs.
